// File: rtl/load_store_unit.sv
// Memory-access stage: issues one load or store on a single-outstanding req/ack bus and returns
// extended load data to the register file, or reports misalignment, bus error or timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ready,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [1:0]  data_size,
    input  logic        extend_sign,
    input  logic [2:0]  rdest,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        wb_enable,
    output logic [2:0]  wb_rdest,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_data_size,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBus, StFinish, StFault} state_e;

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_byte_en_q, mem_byte_en_d;
    logic            wb_enable_q, wb_enable_d;
    logic [2:0]      wb_rdest_q, wb_rdest_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;
    logic [1:0]      fault_cause_q, fault_cause_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            store_q, store_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic [2:0]      rdest_q, rdest_d;

    logic        misaligned;
    logic [3:0]  new_byte_en;
    logic [31:0] new_wdata;
    logic [31:0] shifted;
    logic [31:0] load_value;

    assign misaligned = ((data_size == 2'b01) && addr[0]) ||
                        (data_size[1] && (addr[1:0] != 2'b00));

    always_comb begin
        new_byte_en = 4'b1111;
        new_wdata   = store_data;
        case (data_size)
            2'b00: begin
                new_byte_en = 4'b0001 << addr[1:0];
                new_wdata   = {4{store_data[7:0]}};
            end
            2'b01: begin
                new_byte_en = 4'b0011 << addr[1:0];
                new_wdata   = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Read data is aligned to the requested byte offset before size masking and extension.
    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_value = shifted;
        case (size_q)
            2'b00:   load_value = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_value = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        ready_d       = ready_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_byte_en_d = mem_byte_en_q;
        wb_enable_d   = 1'b0;
        wb_rdest_d    = wb_rdest_q;
        wb_data_d     = wb_data_q;
        done_d        = 1'b0;
        fault_d       = 1'b0;
        fault_cause_d = fault_cause_q;
        cnt_d         = cnt_q;
        store_d       = store_q;
        off_d         = off_q;
        size_d        = size_q;
        sign_d        = sign_q;
        rdest_d       = rdest_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ready_d       = 1'b0;
                    store_d       = is_store;
                    off_d         = addr[1:0];
                    size_d        = data_size;
                    sign_d        = extend_sign;
                    rdest_d       = rdest;
                    fault_cause_d = 2'b00;
                    if (misaligned) begin
                        fault_d       = 1'b1;
                        fault_cause_d = 2'b01;
                        state_d       = StFault;
                    end else begin
                        mem_req_d     = 1'b1;
                        mem_we_d      = is_store;
                        mem_addr_d    = {addr[31:2], 2'b00};
                        mem_wdata_d   = is_store ? new_wdata : 32'h0;
                        mem_byte_en_d = new_byte_en;
                        cnt_d         = '0;
                        state_d       = StBus;
                    end
                end
            end
            StBus: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (mem_err) begin
                        fault_d       = 1'b1;
                        fault_cause_d = 2'b10;
                        state_d       = StFault;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StFinish;
                        if (!store_q) begin
                            wb_enable_d = 1'b1;
                            wb_rdest_d  = rdest_q;
                            wb_data_d   = load_value;
                        end
                    end
                end else if (cnt_q == CntLast) begin
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'b11;
                    state_d       = StFault;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StFinish, StFault: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ready_q       <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_byte_en_q <= 4'h0;
            wb_enable_q   <= 1'b0;
            wb_rdest_q    <= 3'h0;
            wb_data_q     <= 32'h0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
            cnt_q         <= '0;
            store_q       <= 1'b0;
            off_q         <= 2'b00;
            size_q        <= 2'b00;
            sign_q        <= 1'b0;
            rdest_q       <= 3'h0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_byte_en_q <= mem_byte_en_d;
            wb_enable_q   <= wb_enable_d;
            wb_rdest_q    <= wb_rdest_d;
            wb_data_q     <= wb_data_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            cnt_q         <= cnt_d;
            store_q       <= store_d;
            off_q         <= off_d;
            size_q        <= size_d;
            sign_q        <= sign_d;
            rdest_q       <= rdest_d;
        end
    end

    assign ready        = ready_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_byte_en  = mem_byte_en_q;
    assign wb_enable    = wb_enable_q;
    assign wb_rdest     = wb_rdest_q;
    assign wb_data      = wb_data_q;
    assign wb_data_size = 2'b10;
    assign done         = done_q;
    assign fault        = fault_q;
    assign fault_cause  = fault_cause_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: hand-written vector table, randomized transactions checked against
// an arithmetic reference model, plus reset and busy-start sequences.
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, start, ready, is_store, extend_sign;
    logic [31:0] addr, store_data;
    logic [1:0]  data_size;
    logic [2:0]  rdest;
    logic        mem_req, mem_we, mem_ack, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_en;
    logic        wb_enable, done, fault;
    logic [2:0]  wb_rdest;
    logic [31:0] wb_data;
    logic [1:0]  wb_data_size, fault_cause;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .is_store(is_store),
        .addr(addr), .store_data(store_data), .data_size(data_size),
        .extend_sign(extend_sign), .rdest(rdest), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .wb_enable(wb_enable), .wb_rdest(wb_rdest), .wb_data(wb_data),
        .wb_data_size(wb_data_size), .done(done), .fault(fault), .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [31:0] a;
        logic [31:0] sd;
        logic [1:0]  sz;
        logic        sg;
        logic [2:0]  rd;
        int          dly;      // ack after this many req cycles; >= TO means never
        logic [31:0] rdata;
        logic        er;
        logic [1:0]  exp_cause;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic [31:0] a, input logic [31:0] sd,
                                input logic [1:0] sz, input logic sg, input logic [2:0] rd,
                                input int dly, input logic [31:0] rdata, input logic er,
                                input logic [1:0] cause, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] wb);
        vec_t v;
        v.st = st; v.a = a; v.sd = sd; v.sz = sz; v.sg = sg; v.rd = rd; v.dly = dly;
        v.rdata = rdata; v.er = er; v.exp_cause = cause; v.exp_be = be;
        v.exp_wdata = wd; v.exp_wb = wb;
        return v;
    endfunction

    // Reference model: fills expectations from the access rules using byte arithmetic.
    function automatic vec_t model(input vec_t v);
        int n, off;
        logic [31:0] val, mask;
        n   = (v.sz == 2'b00) ? 1 : (v.sz == 2'b01) ? 2 : 4;
        off = int'(v.a % 4);
        if (int'(v.a % n) != 0)  v.exp_cause = 2'b01;
        else if (v.dly >= TO)    v.exp_cause = 2'b11;
        else if (v.er)           v.exp_cause = 2'b10;
        else                     v.exp_cause = 2'b00;
        v.exp_be = 4'h0;
        v.exp_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + n) v.exp_be[i] = 1'b1;
            if (v.st) v.exp_wdata[8*i +: 8] = v.sd[8*(i % n) +: 8];
        end
        val = v.rdata >> (8 * off);
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            val = val & mask;
            if (v.sg && val[8*n-1]) val = val | ~mask;
        end
        v.exp_wb = val;
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 10 && ready !== 1'b1; i++) step();
        chk({tag, " ready before start"}, ready, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic ok, wb;
        wait_ready(tag);
        start = 1'b1; is_store = v.st; addr = v.a; store_data = v.sd; data_size = v.sz;
        extend_sign = v.sg; rdest = v.rd;
        step();
        start = 1'b0;
        if (v.exp_cause == 2'b01) begin
            chk({tag, " misaligned fault"}, fault, 1'b1);
            chk({tag, " misaligned cause"}, fault_cause, 2'b01);
            chk({tag, " misaligned no req"}, mem_req, 1'b0);
            chk({tag, " misaligned ready low"}, ready, 1'b0);
            step();
            chk({tag, " fault pulse ends"}, fault, 1'b0);
            chk({tag, " ready after fault"}, ready, 1'b1);
            chk({tag, " cause held"}, fault_cause, 2'b01);
            chk({tag, " still no req"}, mem_req, 1'b0);
            return;
        end
        for (int k = 0; k < TO; k++) begin
            chk({tag, " mem_req"}, mem_req, 1'b1);
            chk({tag, " mem_we"}, mem_we, v.st);
            chk({tag, " mem_addr"}, mem_addr, v.a & 32'hFFFF_FFFC);
            chk({tag, " mem_byte_en"}, mem_byte_en, v.exp_be);
            chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
            chk({tag, " done early"}, done, 1'b0);
            chk({tag, " fault early"}, fault, 1'b0);
            if (k == v.dly) begin
                mem_ack = 1'b1; mem_rdata = v.rdata; mem_err = v.er;
                step();
                mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
                break;
            end
            step();
        end
        ok = (v.exp_cause == 2'b00);
        wb = ok && !v.st;
        chk({tag, " req dropped"}, mem_req, 1'b0);
        chk({tag, " done"}, done, ok);
        chk({tag, " fault"}, fault, !ok);
        chk({tag, " wb_enable"}, wb_enable, wb);
        chk({tag, " ready low"}, ready, 1'b0);
        if (!ok) chk({tag, " fault_cause"}, fault_cause, v.exp_cause);
        if (wb) begin
            chk({tag, " wb_rdest"}, wb_rdest, v.rd);
            chk({tag, " wb_data"}, wb_data, v.exp_wb);
            chk({tag, " wb_data_size"}, wb_data_size, 2'b10);
        end
        step();
        chk({tag, " done pulse ends"}, done, 1'b0);
        chk({tag, " fault pulse ends"}, fault, 1'b0);
        chk({tag, " wb pulse ends"}, wb_enable, 1'b0);
        chk({tag, " ready back"}, ready, 1'b1);
        chk({tag, " cause held"}, fault_cause, v.exp_cause);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t r;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; addr = '0; store_data = '0;
        data_size = '0; extend_sign = 1'b0; rdest = '0;
        mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        step(); step();
        rst = 1'b0;

        chk("reset ready", ready, 1'b1);
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset mem_byte_en", mem_byte_en, 4'h0);
        chk("reset wb_enable", wb_enable, 1'b0);
        chk("reset wb_rdest", wb_rdest, 3'h0);
        chk("reset wb_data", wb_data, 32'h0);
        chk("reset wb_data_size", wb_data_size, 2'b10);
        chk("reset done", done, 1'b0);
        chk("reset fault", fault, 1'b0);
        chk("reset fault_cause", fault_cause, 2'b00);

        vecs.push_back(mk(0, 32'h1003, 0, 2'b00, 1, 5, 2, 32'h80112233, 0,
                          2'b00, 4'b1000, 32'h0, 32'hFFFFFF80));
        vecs.push_back(mk(1, 32'h22, 32'hDEADBEEF, 2'b01, 0, 0, 0, 32'h0, 0,
                          2'b00, 4'b1100, 32'hBEEFBEEF, 32'h0));
        vecs.push_back(mk(0, 32'h102, 0, 2'b10, 0, 1, 0, 32'h0, 0,
                          2'b01, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 32'h2, 0, 2'b01, 0, 3, 1, 32'hABCD0000, 0,
                          2'b00, 4'b1100, 32'h0, 32'h0000ABCD));
        vecs.push_back(mk(0, 32'h40, 0, 2'b10, 0, 2, 15, 32'h0, 0,
                          2'b11, 4'b1111, 32'h0, 32'h0));
        vecs.push_back(mk(1, 32'h41, 32'h000000A5, 2'b00, 0, 0, 1, 32'h0, 1,
                          2'b10, 4'b0010, 32'hA5A5A5A5, 32'h0));
        vecs.push_back(mk(0, 32'h0, 0, 2'b01, 1, 7, 0, 32'h12348001, 0,
                          2'b00, 4'b0011, 32'h0, 32'hFFFF8001));
        vecs.push_back(mk(1, 32'h100, 32'h11223344, 2'b10, 0, 0, 3, 32'h0, 0,
                          2'b00, 4'b1111, 32'h11223344, 32'h0));
        vecs.push_back(mk(0, 32'h2, 0, 2'b00, 0, 4, 0, 32'h00C30000, 0,
                          2'b00, 4'b0100, 32'h0, 32'h000000C3));
        vecs.push_back(mk(1, 32'h3, 32'h1, 2'b01, 0, 0, 0, 32'h0, 0,
                          2'b01, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 32'h8, 0, 2'b11, 1, 6, 1, 32'hF0F01234, 0,
                          2'b00, 4'b1111, 32'h0, 32'hF0F01234));
        vecs.push_back(mk(0, 32'h1, 0, 2'b00, 1, 2, 3, 32'h00007F00, 0,
                          2'b00, 4'b0010, 32'h0, 32'h0000007F));
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset on the second req cycle, then a stray ack while idle.
        wait_ready("rst seq");
        start = 1'b1; is_store = 1'b0; addr = 32'h10; data_size = 2'b10; rdest = 3'd6;
        step();
        start = 1'b0;
        step();
        chk("rst seq req before reset", mem_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst seq req dropped", mem_req, 1'b0);
        chk("rst seq ready", ready, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_ack = 1'b0;
        chk("rst seq no done", done, 1'b0);
        chk("rst seq no fault", fault, 1'b0);
        chk("rst seq no wb", wb_enable, 1'b0);
        chk("rst seq idle req", mem_req, 1'b0);
        step();
        chk("rst seq no late done", done, 1'b0);
        chk("rst seq no late wb", wb_enable, 1'b0);
        run_vec(vecs[0], "after rst");

        // A start presented while busy must not disturb the running transaction.
        wait_ready("busy seq");
        start = 1'b1; is_store = 1'b0; addr = 32'h201; data_size = 2'b00; extend_sign = 1'b0;
        rdest = 3'd1;
        step();
        is_store = 1'b1; addr = 32'h300; store_data = 32'hFFFFFFFF; rdest = 3'd7;
        step();
        chk("busy seq mem_addr", mem_addr, 32'h200);
        chk("busy seq mem_we", mem_we, 1'b0);
        chk("busy seq byte_en", mem_byte_en, 4'b0010);
        mem_ack = 1'b1; mem_rdata = 32'h0000AA00; start = 1'b0;
        step();
        mem_ack = 1'b0;
        chk("busy seq done", done, 1'b1);
        chk("busy seq wb_rdest", wb_rdest, 3'd1);
        chk("busy seq wb_data", wb_data, 32'h000000AA);
        step();
        chk("busy seq ready", ready, 1'b1);
        step();
        chk("busy seq no extra req", mem_req, 1'b0);

        for (int i = 0; i < 60; i++) begin
            r.st = 1'($urandom_range(0, 1));
            r.a = $urandom;
            r.sd = $urandom;
            r.sz = 2'($urandom_range(0, 3));
            r.sg = 1'($urandom_range(0, 1));
            r.rd = 3'($urandom_range(0, 7));
            r.dly = $urandom_range(0, 5);
            r.rdata = $urandom;
            r.er = ($urandom_range(0, 7) == 0);
            run_vec(model(r), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between execute and register-file writeback.
- Accepts one load or store per transaction:
  - address from the ALU;
  - store data from the full-width source-2 register value;
  - access size and sign-extend flag.
- Drives a single-outstanding req/ack memory bus. For loads, it returns a fully extended 32-bit result to the register-file write port.
- Detects misalignment, bus error and bus timeout, and reports them as a fault instead of touching memory or registers.

Parameters:
- TIMEOUT_CYCLES, 255, cycles `mem_req` may stay high without `mem_ack` before the transaction faults. Must be ≥1.

Ports:
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: transaction request; accepted only when `ready`=1.
- `ready` output 1: unit idle and able to accept `start`.
- `is_store` input 1: 1=store, 0=load.
- `addr` input 32: byte address.
- `store_data` input 32: full-width register value to store.
- `data_size` input 2: 00 byte, 01 halfword, 10/11 word.
- `extend_sign` input 1: loads only; 1=sign-extend, 0=zero-extend.
- `rdest` input 3: load destination register.
- `mem_req` output 1: bus request.
- `mem_we` output 1: bus write.
- `mem_addr` output 32: word-aligned bus address, {`addr`[31:2],2'b00}.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_byte_en` output 4: active byte lanes.
- `mem_ack` input 1: bus completion.
- `mem_rdata` input 32: read data, valid with `mem_ack`.
- `mem_err` input 1: bus error, valid with `mem_ack`.
- `wb_enable` output 1: register-file write strobe.
- `wb_rdest` output 3: register-file write index.
- `wb_data` output 32: extended load result.
- `wb_data_size` output 2: constant 2'b10 (full-word write).
- `done` output 1: one-cycle pulse on successful completion.
- `fault` output 1: one-cycle pulse on failed transaction.
- `fault_cause` output 2: 01 misaligned, 10 bus error, 11 timeout; held until the next `start`.

Behaviour:
- **States:** IDLE, BUS, FINISH, FAULT. All outputs are registered.
- **Reset values:**
  - state=IDLE, `ready`=1.
  - `mem_req`, `mem_we`, `wb_enable`, `done`, `fault` = 0.
  - `mem_addr`, `mem_wdata`, `wb_data` = 0; `mem_byte_en`=0; `wb_rdest`=0; `fault_cause`=00.
- **IDLE:**
  - On `start`, latch all inputs and set `ready`=0.
  - Misaligned request (halfword with `addr`[0]=1, or word with `addr`[1:0]≠00) → FAULT with cause 01. No bus activity.
  - Otherwise → BUS, with `mem_req`=1 from the next cycle. `start` is cycle N, `mem_req` is first high at N+1.
- **Byte enables:**
  - byte: 4'b0001<<`addr`[1:0]
  - half: 4'b0011<<`addr`[1:0]
  - word: 4'b1111
- **Write data:**
  - byte: {4{`store_data`[7:0]}}
  - half: {2{`store_data`[15:0]}}
  - word: `store_data`
  - For loads, `mem_we`=0 and `mem_wdata`=0.
- **BUS:**
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_byte_en` stay stable until `mem_ack`.
  - `mem_ack` is legal in the first `mem_req` cycle.
  - A timeout counter counts `mem_req` cycles. If it reaches TIMEOUT_CYCLES with no `mem_ack` → FAULT, cause 11.
  - `mem_ack` with `mem_err`=1 → FAULT, cause 10.
  - `mem_ack` with `mem_err`=0 → FINISH.
  - `mem_req` drops in the cycle after `mem_ack`.
- **Load extraction (computed at ack):**
  - Shift `mem_rdata` right by `addr`[1:0]×8.
  - Take the low 8 bits (byte) or 16 bits (half); word uses all 32 bits.
  - Extend to 32 bits per `extend_sign`.
- **FINISH:** lasts one cycle.
  - `done`=1.
  - For loads only: `wb_enable`=1, `wb_rdest`=latched `rdest`, `wb_data`=extended value.
  - → IDLE, with `ready`=1 in the following cycle.
  - Ack at cycle M gives `done` at M+1 and `ready` at M+2.
- **FAULT:** lasts one cycle.
  - `fault`=1, `wb_enable`=0 (no register write).
  - → IDLE.
- `start` while `ready`=0 is ignored.
- **Reset mid-transaction:** `mem_req` drops the cycle after `rst`. No `wb_enable`, `done` or `fault`. A later `mem_ack` while IDLE is ignored.

Test Plan:
- Load byte, `addr`=0x1003, `extend_sign`=1, `rdest`=5, `mem_rdata`=0x80112233 acked 2 cycles after `mem_req`:
  - bus: `mem_addr`=0x1000, `mem_byte_en`=1000;
  - `wb_enable` pulse with `wb_rdest`=5, `wb_data`=0xFFFFFF80, `wb_data_size`=10, `done`=1.
- Store half, `addr`=0x22, `store_data`=0xDEADBEEF, ack in first cycle:
  - bus: `mem_we`=1, `mem_byte_en`=1100, `mem_wdata`=0xBEEFBEEF;
  - `done` at ack+1, no `wb_enable`, `ready` at ack+2.
- Load word, `addr`=0x102 → `fault`=1 with `fault_cause`=01 the cycle after `start`; `mem_req` never asserts.
- Load half zero-extend, `addr`=0x2, `mem_rdata`=0xABCD0000 → `wb_data`=0x0000ABCD.
- TIMEOUT_CYCLES=4, `mem_ack` never asserted → `mem_req` high exactly 4 cycles, then `fault`=1 with cause 11. Also: `mem_ack`+`mem_err` → cause 10, no `wb_enable`.
- `rst` asserted on the second `mem_req` cycle, then `mem_ack`:
  - `mem_req`=0 and `ready`=1 after reset;
  - no `done`, `fault` or `wb_enable`;
  - a new `start` is accepted normally.
